// File: rtl/ice40_carry_pkg.sv
// Shared types and sizing helpers for the iCE40 carry-chain scheduler.
package ice40_carry_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Limb counter must hold 0..limbs inclusive.
  function automatic int cnt_w(input int limbs);
    return $clog2(limbs + 1);
  endfunction

  function automatic int id_w(input int n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = id_w(N_REQ_DEF);

endpackage

// File: rtl/ice40_limb_add.sv
// One W-bit limb of the shared fabric carry chain: {co,sum} = a + b + ci.
module ice40_limb_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  // A plain ripple add maps directly onto SB_LUT4 sum cells plus the SB_CARRY chain.
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/ice40_carry_sched.sv
// Round-robin scheduler sharing one carry-chain adder among N_REQ multi-limb add/sub streams.
module ice40_carry_sched
  import ice40_carry_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = 8,
  parameter int LIMBS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*W-1:0]        req_a,
  input  logic [N_REQ*W-1:0]        req_b,
  input  logic [N_REQ-1:0]          req_ci,
  input  logic [N_REQ-1:0]          req_sub,
  input  logic [N_REQ-1:0]          req_last,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [W-1:0]              res_sum,
  output logic                      res_co,
  output logic [id_w(N_REQ)-1:0]    res_id,
  output logic                      res_last,
  output logic                      res_ovf
);

  localparam int IDW = id_w(N_REQ);
  localparam int CW  = cnt_w(LIMBS);

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d, rr_q, pick;
  logic             pick_vld;
  logic [CW-1:0]    cnt_q, cnt_inc;
  logic             carry_q, sub_q;

  logic [W-1:0]     a_sel, b_sel, eff_b, sum_c;
  logic             co_c, cin, sub_eff, first, out_free, accept, hit_lim, done;

  logic             vld_p1, co_p1, last_p1, ovf_p1;
  logic [W-1:0]     sum_p1;
  logic [IDW-1:0]   id_p1;

  // Lowest rotated offset from the RR pointer wins, so scan from the far end down.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_q) + i) % N_REQ;
      if (req_valid[idx]) begin
        pick     = IDW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign a_sel    = req_a[int'(grant_q)*W +: W];
  assign b_sel    = req_b[int'(grant_q)*W +: W];
  assign out_free = !vld_p1 || res_ready;
  assign accept   = (state_q == BUSY) && req_valid[grant_q] && out_free;
  assign first    = (cnt_q == '0);
  assign sub_eff  = first ? req_sub[grant_q] : sub_q;
  assign cin      = first ? (sub_eff | req_ci[grant_q]) : carry_q;
  assign eff_b    = sub_eff ? ~b_sel : b_sel;
  assign cnt_inc  = cnt_q + 1'b1;
  assign hit_lim  = (cnt_inc == CW'(LIMBS));
  assign done     = req_last[grant_q] | hit_lim;

  ice40_limb_add #(.W(W)) u_add (
    .a   (a_sel),
    .b   (eff_b),
    .ci  (cin),
    .sum (sum_c),
    .co  (co_c)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        req_ready[grant_q] = out_free;
        if (accept && done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (accept) begin
        carry_q <= co_c;
        sub_q   <= sub_eff;
        cnt_q   <= done ? '0 : cnt_inc;
        if (done) rr_q <= (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  // Stage p1: one-deep result register, reloadable in the same cycle it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      co_p1   <= 1'b0;
      id_p1   <= '0;
      last_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      sum_p1  <= sum_c;
      co_p1   <= co_c;
      id_p1   <= grant_q;
      last_p1 <= done;
      ovf_p1  <= hit_lim && !req_last[grant_q];
    end else if (res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign res_valid = vld_p1;
  assign res_sum   = sum_p1;
  assign res_co    = co_p1;
  assign res_id    = id_p1;
  assign res_last  = last_p1;
  assign res_ovf   = ovf_p1;

endmodule

// File: tb/tb_ice40_carry_sched.sv
// Directed bench for ice40_carry_sched with an operation-level scoreboard model.
module tb_ice40_carry_sched;
  import ice40_carry_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int LIMBS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, req_ci, req_sub, req_last;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   a_v [N];
  logic [W-1:0]   b_v [N];
  logic           res_valid, res_ready, res_co, res_last, res_ovf;
  logic [W-1:0]   res_sum;
  logic [ID_W-1:0] res_id;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
    end
  end

  ice40_carry_sched #(.N_REQ(N), .W(W), .LIMBS(LIMBS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_sub(req_sub), .req_last(req_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_co(res_co), .res_id(res_id), .res_last(res_last), .res_ovf(res_ovf)
  );

  typedef struct packed {
    logic [W-1:0]    sum;
    logic            co;
    logic [ID_W-1:0] id;
    logic            last;
    logic            ovf;
  } res_t;

  res_t expq[$];
  res_t logq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] s, input logic c, input int id,
                              input logic l, input logic o);
    res_t r;
    r.sum = s; r.co = c; r.id = ID_W'(id); r.last = l; r.ovf = o;
    return r;
  endfunction

  // Operation-level model: per requester, remember whether an op is open, its carry, mode and limb count.
  bit   in_op   [N];
  bit   m_carry [N];
  bit   m_sub   [N];
  int   m_cnt   [N];
  res_t prev;
  bit   prev_stall = 1'b0;

  always @(negedge clk) begin
    res_t cur, e;
    logic s, cin;
    logic [W-1:0] bb;
    logic [W:0] t;
    if (rst) begin
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      expq.delete();
      for (int i = 0; i < N; i++) begin in_op[i] = 1'b0; m_cnt[i] = 0; end
      prev_stall = 1'b0;
    end else begin
      cur = {res_sum, res_co, res_id, res_last, res_ovf};
      if (prev_stall) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_data", 32'(cur), 32'(prev));
      end
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (res_valid && !res_ready) chk("ready_while_full", 32'(req_ready), 32'd0);
      if (res_valid && res_ready) begin
        if (expq.size() == 0) chk("unexpected_result", 32'(cur), 32'h1fff_ffff);
        else begin
          e = expq.pop_front();
          chk("result", 32'(cur), 32'(e));
          logq.push_back(cur);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          s   = in_op[i] ? m_sub[i] : req_sub[i];
          cin = in_op[i] ? m_carry[i] : (s ? 1'b1 : req_ci[i]);
          bb  = s ? ~b_v[i] : b_v[i];
          t   = {1'b0, a_v[i]} + {1'b0, bb} + {{W{1'b0}}, cin};
          m_cnt[i]++;
          e = mk(t[W-1:0], t[W], i, req_last[i] || (m_cnt[i] == LIMBS),
                 (m_cnt[i] == LIMBS) && !req_last[i]);
          expq.push_back(e);
          if (e.last) begin in_op[i] = 1'b0; m_cnt[i] = 0; end
          else begin in_op[i] = 1'b1; m_carry[i] = t[W]; m_sub[i] = s; end
        end
      end
      prev_stall = res_valid && !res_ready;
      prev = cur;
    end
  end

  // Caller is aligned just after a rising edge; returns aligned the same way after the accept.
  task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sub, input logic last);
    int n;
    a_v[id] = a; b_v[id] = b;
    req_ci[id] = ci; req_sub[id] = sub; req_last[id] = last; req_valid[id] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[id] && n < 200);
    if (n >= 200) chk("send_timeout", 32'(id), 32'hffff);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || res_valid) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 32'(expq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic lit(input string nm, input int idx, input res_t e);
    if (idx >= logq.size()) chk({nm, "_missing"}, 32'(logq.size()), 32'(idx + 1));
    else chk(nm, 32'(logq[idx]), 32'(e));
  endtask

  initial begin
    int base;
    rst = 1'b1; res_ready = 1'b1;
    req_valid = '0; req_ci = '0; req_sub = '0; req_last = '0;
    for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;

    base = logq.size();
    send(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    send(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();
    lit("add_limb0", base,     mk(8'h00, 1'b1, 0, 1'b0, 1'b0));
    lit("add_limb1", base + 1, mk(8'h01, 1'b0, 0, 1'b1, 1'b0));

    base = logq.size();
    send(2, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
    drain();
    lit("sub_single", base, mk(8'hFE, 1'b0, 2, 1'b1, 1'b0));

    do_reset();
    base = logq.size();
    fork
      send(1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
      send(3, 8'h30, 8'h40, 1'b1, 1'b0, 1'b1);
    join
    drain();
    fork
      send(0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
      send(1, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
    join
    drain();
    lit("rr_first_1",  base,     mk(8'h30, 1'b0, 1, 1'b1, 1'b0));
    lit("rr_then_3",   base + 1, mk(8'h71, 1'b0, 3, 1'b1, 1'b0));
    lit("rr_wrap_0",   base + 2, mk(8'h03, 1'b0, 0, 1'b1, 1'b0));
    lit("rr_then_1",   base + 3, mk(8'h07, 1'b0, 1, 1'b1, 1'b0));

    base = logq.size();
    fork
      begin
        send(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        send(0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        send(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      end
      begin
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 200);
        @(posedge clk); #1 res_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
      end
    join
    drain();
    lit("stall_limb0", base,     mk(8'h00, 1'b1, 0, 1'b0, 1'b0));
    lit("stall_limb1", base + 1, mk(8'h00, 1'b1, 0, 1'b0, 1'b0));
    lit("stall_limb2", base + 2, mk(8'h01, 1'b0, 0, 1'b1, 1'b0));

    base = logq.size();
    for (int k = 0; k < 5; k++) send(2, 8'hFF, 8'h01, 1'b0, 1'b0, (k == 4));
    drain();
    lit("ovf_limb1",  base + 1, mk(8'h01, 1'b1, 2, 1'b0, 1'b0));
    lit("ovf_limb3",  base + 3, mk(8'h01, 1'b1, 2, 1'b1, 1'b1));
    lit("ovf_newop",  base + 4, mk(8'h00, 1'b1, 2, 1'b1, 1'b0));

    send(0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    send(0, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    base = logq.size();
    fork
      send(3, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
      send(1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
    join
    drain();
    lit("post_abort_1", base,     mk(8'h04, 1'b0, 1, 1'b1, 1'b0));
    lit("post_abort_3", base + 1, mk(8'h02, 1'b0, 3, 1'b1, 1'b0));

    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
